// File: rtl/memdump_streamer.sv
// -----------------------------------------------------------------------------
// memdump_streamer
//
// Post-halt memory dump engine. Watches the write-back opcode and, on the first
// TRAP (opcode 6'h11) after reset, freezes the core and walks the data-memory
// window [START_ADDR, END_ADDR) in steps of ADDR_STEP. Each word is read
// through a single-cycle-latency read port and streamed out on a valid/ready
// interface in address order. Exactly one dump happens per reset; the engine
// then parks in DONE with the core still halted.
//
// Optional feature macro: MEMDUMP_CHECKSUM_EN
//   When defined, a running 32-bit sum of all dumped words is kept, and one
//   extra beat (out_addr = 32'hFFFFFFFF, out_data = sum, out_last = 1) follows
//   the data beats. When undefined, out_last marks the final data word.
//
// Parameters:
//   START_ADDR  first word index dumped
//   END_ADDR    exclusive end word index (unsigned compare)
//   ADDR_STEP   address increment per word (32-bit, wraps mod 2^32)
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   wb_opcode  in   [5:0] opcode of the instruction in write-back
//   cpu_halt   out  freezes the core; set at TRAP, held until reset
//   mem_re     out  data-memory read strobe (one cycle per word)
//   mem_addr   out  [31:0] data-memory read address
//   mem_rdata  in   [31:0] read data, valid the cycle after mem_re
//   out_valid  out  stream beat valid
//   out_ready  in   stream sink accepts the beat
//   out_data   out  [31:0] beat payload
//   out_addr   out  [31:0] word address of the payload
//   out_last   out  final beat of the dump
//   dump_done  out  one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module memdump_streamer #(
    parameter logic [31:0] START_ADDR = 32'd8192,
    parameter logic [31:0] END_ADDR   = 32'd8292,
    parameter logic [31:0] ADDR_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  wb_opcode,
    output logic        cpu_halt,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_last,
    output logic        dump_done
);

    localparam logic [5:0] TRAP_OPCODE = 6'h11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
`ifdef MEMDUMP_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd4;
`endif
    localparam logic [2:0] ST_DONE = 3'd5;

    // Address used to tag the checksum beat so the sink can tell it from data.
    localparam logic [31:0] CSUM_ADDR = 32'hFFFF_FFFF;

    // Window is known empty at elaboration time; TRAP then skips all reads.
    localparam logic EMPTY_WINDOW = (START_ADDR >= END_ADDR) ? 1'b1 : 1'b0;

    logic [2:0]  state_q,     state_d;
    logic [31:0] cur_q,       cur_d;
    logic        cpu_halt_q,  cpu_halt_d;
    logic        mem_re_q,    mem_re_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q,  out_data_d;
    logic [31:0] out_addr_q,  out_addr_d;
    logic        out_last_q,  out_last_d;
    logic        dump_done_q, dump_done_d;
`ifdef MEMDUMP_CHECKSUM_EN
    logic [31:0] sum_q,       sum_d;
`endif

    logic        trap_s;
    logic [31:0] next_addr_s;
    logic        at_end_s;

    assign trap_s      = (wb_opcode == TRAP_OPCODE) ? 1'b1 : 1'b0;
    // Wrapping add; the end test is an unsigned compare on the wrapped value.
    assign next_addr_s = cur_q + ADDR_STEP;
    assign at_end_s    = (next_addr_s >= END_ADDR) ? 1'b1 : 1'b0;

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cpu_halt_d  = cpu_halt_q;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        dump_done_d = 1'b0;
`ifdef MEMDUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (trap_s) begin
                    cpu_halt_d = 1'b1;
                    cur_d      = START_ADDR;
`ifdef MEMDUMP_CHECKSUM_EN
                    sum_d      = 32'd0;
`endif
                    if (EMPTY_WINDOW) begin
`ifdef MEMDUMP_CHECKSUM_EN
                        // Only the checksum beat (value 0) is sent.
                        state_d     = ST_CSUM;
                        out_valid_d = 1'b1;
                        out_data_d  = 32'd0;
                        out_addr_d  = CSUM_ADDR;
                        out_last_d  = 1'b1;
`else
                        state_d     = ST_DONE;
                        dump_done_d = 1'b1;
`endif
                    end else begin
                        // Issue the first read on the TRAP edge itself.
                        state_d    = ST_READ;
                        mem_re_d   = 1'b1;
                        mem_addr_d = START_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_READ: begin
                // mem_re is high during this state only; data returns next cycle.
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                state_d     = ST_SEND;
                out_valid_d = 1'b1;
                out_data_d  = mem_rdata;
                out_addr_d  = cur_q;
`ifdef MEMDUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                sum_d       = sum_q + mem_rdata;
`else
                out_last_d  = at_end_s;
`endif
            end

            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (!at_end_s) begin
                        // Next read goes out on the handshake edge.
                        state_d    = ST_READ;
                        cur_d      = next_addr_s;
                        mem_re_d   = 1'b1;
                        mem_addr_d = next_addr_s;
                    end else begin
`ifdef MEMDUMP_CHECKSUM_EN
                        state_d     = ST_CSUM;
                        out_valid_d = 1'b1;
                        out_data_d  = sum_q;
                        out_addr_d  = CSUM_ADDR;
                        out_last_d  = 1'b1;
`else
                        state_d     = ST_DONE;
                        dump_done_d = 1'b1;
`endif
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

`ifdef MEMDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (out_ready) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    dump_done_d = 1'b1;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif

            ST_DONE: begin
                // Sticky until reset; further TRAPs are ignored.
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= 32'd0;
            cpu_halt_q  <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_addr_q  <= 32'd0;
            out_last_q  <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cpu_halt_q  <= cpu_halt_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            dump_done_q <= dump_done_d;
        end
    end

`ifdef MEMDUMP_CHECKSUM_EN
    // Running checksum of dumped words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign cpu_halt  = cpu_halt_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign dump_done = dump_done_q;

endmodule

// File: tb/tb_memdump_streamer.sv
// -----------------------------------------------------------------------------
// tb_memdump_streamer
//
// Directed bench for memdump_streamer. A main instance dumps window
// 8192..8195 holding words 1, 1, 2, 3; a second instance has an empty window
// (START_ADDR = END_ADDR = 100). A small single-cycle-latency memory model
// feeds the main instance. Scenarios: reset values, free-flowing dump with
// exact latency, TRAP after DONE, stalled beat with a TRAP mid-dump,
// reset mid-SEND followed by a fresh dump, and the empty window.
// -----------------------------------------------------------------------------
module tb_memdump_streamer;

`ifdef MEMDUMP_CHECKSUM_EN
    localparam logic LAST_DATA = 1'b0;
    localparam int   BEATS     = 5;
`else
    localparam logic LAST_DATA = 1'b1;
    localparam int   BEATS     = 4;
`endif

    logic        clk;
    logic        reset;
    logic [5:0]  wb_opcode;
    logic        cpu_halt;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_last;
    logic        dump_done;

    logic [5:0]  e_opcode;
    logic        e_cpu_halt;
    logic        e_mem_re;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_rdata;
    logic        e_out_valid;
    logic        e_out_ready;
    logic [31:0] e_out_data;
    logic [31:0] e_out_addr;
    logic        e_out_last;
    logic        e_dump_done;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int done_count = 0;
    int overlap_count = 0;

    logic [31:0] mem_words [0:3];
    logic [31:0] exp_words [0:3];

    memdump_streamer #(
        .START_ADDR(32'd8192),
        .END_ADDR  (32'd8196),
        .ADDR_STEP (32'd1)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .wb_opcode(wb_opcode),
        .cpu_halt (cpu_halt),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_last (out_last),
        .dump_done(dump_done)
    );

    memdump_streamer #(
        .START_ADDR(32'd100),
        .END_ADDR  (32'd100),
        .ADDR_STEP (32'd1)
    ) u_empty (
        .clk      (clk),
        .reset    (reset),
        .wb_opcode(e_opcode),
        .cpu_halt (e_cpu_halt),
        .mem_re   (e_mem_re),
        .mem_addr (e_mem_addr),
        .mem_rdata(e_mem_rdata),
        .out_valid(e_out_valid),
        .out_ready(e_out_ready),
        .out_data (e_out_data),
        .out_addr (e_out_addr),
        .out_last (e_out_last),
        .dump_done(e_dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: read data is valid the cycle after the mem_re cycle.
    always @(posedge clk) begin
        if (mem_re) begin
            if (mem_addr >= 32'd8192 && mem_addr < 32'd8196) begin
                mem_rdata <= mem_words[mem_addr[1:0]];
            end else begin
                mem_rdata <= 32'hBAD0_0BAD;
            end
        end else begin
            mem_rdata <= 32'hDEAD_BEEF;
        end
    end

    // Stream/handshake observers.
    always @(posedge clk) begin
        if (out_valid && out_ready) hs_count <= hs_count + 1;
        if (dump_done) done_count <= done_count + 1;
        if (mem_re && out_valid) overlap_count <= overlap_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid_timeout"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic l);
        wait_valid(tag);
        check({tag, "_addr"}, out_addr, a);
        check({tag, "_data"}, out_data, d);
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
    endtask

    task automatic pulse_trap();
        wb_opcode = 6'h11;
        tick();
        wb_opcode = 6'h00;
    endtask

    // Called right after pulse_trap (at edge E + 1). A beat index of -1
    // means no stall; otherwise that beat is held with out_ready low for
    // 5 cycles while a second TRAP is presented.
    task automatic full_dump(input string tag, input int stall_beat);
        logic [31:0] a;
        check({tag, "_halt_E"}, {31'd0, cpu_halt}, 32'd1);
        check({tag, "_re_E"}, {31'd0, mem_re}, 32'd1);
        check({tag, "_raddr_E"}, mem_addr, 32'd8192);
        tick();
        check({tag, "_re_E1"}, {31'd0, mem_re}, 32'd0);
        check({tag, "_valid_E1"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_valid_E2"}, {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            a = 32'd8192 + 32'(k);
            expect_beat(tag, a, exp_words[k], (k == 3) ? LAST_DATA : 1'b0);
            if (k == stall_beat) begin
                out_ready = 1'b0;
                wb_opcode = 6'h11;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
                    check({tag, "_stall_data"}, out_data, exp_words[k]);
                    check({tag, "_stall_addr"}, out_addr, a);
                    check({tag, "_stall_re"}, {31'd0, mem_re}, 32'd0);
                end
                wb_opcode = 6'h00;
                out_ready = 1'b1;
            end
            tick();
        end
`ifdef MEMDUMP_CHECKSUM_EN
        expect_beat({tag, "_csum"}, 32'hFFFF_FFFF, 32'd7, 1'b1);
        tick();
`endif
        check({tag, "_done_pulse"}, {31'd0, dump_done}, 32'd1);
        check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_done_clear"}, {31'd0, dump_done}, 32'd0);
        check({tag, "_halt_held"}, {31'd0, cpu_halt}, 32'd1);
    endtask

    initial begin
        int hs_base;
        int done_base;

        mem_words[0] = 32'd1;
        mem_words[1] = 32'd1;
        mem_words[2] = 32'd2;
        mem_words[3] = 32'd3;
        exp_words[0] = 32'd1;
        exp_words[1] = 32'd1;
        exp_words[2] = 32'd2;
        exp_words[3] = 32'd3;
        reset       = 1'b1;
        wb_opcode   = 6'h00;
        out_ready   = 1'b1;
        e_opcode    = 6'h00;
        e_out_ready = 1'b1;
        e_mem_rdata = 32'h0000_0005;

        // Reset values.
        #1;
        check("rst_halt", {31'd0, cpu_halt}, 32'd0);
        check("rst_re", {31'd0, mem_re}, 32'd0);
        check("rst_raddr", mem_addr, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_oaddr", out_addr, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_done", {31'd0, dump_done}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (7) tick();

        // Free-flowing dump, then a TRAP after DONE.
        hs_base   = hs_count;
        done_base = done_count;
        pulse_trap();
        full_dump("flow", -1);
        wb_opcode = 6'h11;
        repeat (3) tick();
        wb_opcode = 6'h00;
        tick();
        check("post_done_valid", {31'd0, out_valid}, 32'd0);
        check("post_done_re", {31'd0, mem_re}, 32'd0);
        check("post_done_halt", {31'd0, cpu_halt}, 32'd1);
        check("flow_beats", 32'(hs_count - hs_base), 32'(BEATS));
        check("flow_done_count", 32'(done_count - done_base), 32'd1);

        // Reset clears the halt asynchronously; then a stalled dump.
        reset = 1'b1;
        #1;
        check("async_halt_clear", {31'd0, cpu_halt}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        hs_base   = hs_count;
        done_base = done_count;
        pulse_trap();
        full_dump("stall", 1);
        repeat (3) tick();
        check("stall_beats", 32'(hs_count - hs_base), 32'(BEATS));
        check("stall_done_count", 32'(done_count - done_base), 32'd1);

        // Reset while the 8194 beat is held in SEND.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        pulse_trap();
        expect_beat("pre_rst", 32'd8192, 32'd1, 1'b0);
        tick();
        expect_beat("pre_rst", 32'd8193, 32'd1, 1'b0);
        tick();
        out_ready = 1'b0;
        expect_beat("pre_rst", 32'd8194, 32'd2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_halt", {31'd0, cpu_halt}, 32'd0);
        check("mid_rst_re", {31'd0, mem_re}, 32'd0);
        check("mid_rst_raddr", mem_addr, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_oaddr", out_addr, 32'd0);
        check("mid_rst_last", {31'd0, out_last}, 32'd0);
        check("mid_rst_done", {31'd0, dump_done}, 32'd0);
        tick();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        pulse_trap();
        full_dump("restart", -1);

        // Empty window instance.
        e_opcode = 6'h11;
        tick();
        e_opcode = 6'h00;
        check("empty_halt", {31'd0, e_cpu_halt}, 32'd1);
        check("empty_re", {31'd0, e_mem_re}, 32'd0);
        check("empty_raddr", e_mem_addr, 32'd0);
`ifdef MEMDUMP_CHECKSUM_EN
        check("empty_valid", {31'd0, e_out_valid}, 32'd1);
        check("empty_data", e_out_data, 32'd0);
        check("empty_oaddr", e_out_addr, 32'hFFFF_FFFF);
        check("empty_last", {31'd0, e_out_last}, 32'd1);
        tick();
        check("empty_done", {31'd0, e_dump_done}, 32'd1);
        check("empty_valid_after", {31'd0, e_out_valid}, 32'd0);
`else
        check("empty_done", {31'd0, e_dump_done}, 32'd1);
        check("empty_valid", {31'd0, e_out_valid}, 32'd0);
        tick();
        check("empty_done_clear", {31'd0, e_dump_done}, 32'd0);
        check("empty_valid_after", {31'd0, e_out_valid}, 32'd0);
`endif

        check("no_re_while_valid", 32'(overlap_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
